// File: rtl/axis_frame_tagger_if.sv
// AXI4-Stream bundle shared by the upstream (camera) and downstream (DMA) sides of axis_frame_tagger.
// The slave modport omits tlast/tuser because the camera source never drives them.
interface axis_frame_tagger_if #(
    parameter int P_AXIS_DATA_WIDTH = 64
) ();
    logic                         tvalid;
    logic                         tready;
    logic [P_AXIS_DATA_WIDTH-1:0] tdata;
    logic                         tlast;
    logic                         tuser;

    modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_frame_tagger.sv
// Tags a raw camera pixel stream with start-of-frame (tuser) and end-of-frame/line (tlast) markers.
// Define AXIS_FRAME_TAGGER_EOL_EN to also mark the last beat of every line with tlast.
module axis_frame_tagger #(
    parameter int P_AXIS_DATA_WIDTH = 64,
    parameter int P_CNT_WIDTH       = 16
) (
    input  logic                   i_axi_clk,
    input  logic                   i_axi_rstn,
    axis_frame_tagger_if.slave     s_axis,
    axis_frame_tagger_if.master    m_axis,
    input  logic                   i_enable,
    input  logic [P_CNT_WIDTH-1:0] i_line_beats_m1,
    input  logic [P_CNT_WIDTH-1:0] i_frame_lines_m1,
    output logic [31:0]            o_frame_cnt,
    output logic                   o_busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [P_CNT_WIDTH-1:0]       beat_cnt;
    logic [P_CNT_WIDTH-1:0]       line_cnt;
    logic [P_CNT_WIDTH-1:0]       line_beats_m1;
    logic [P_CNT_WIDTH-1:0]       frame_lines_m1;
    logic [31:0]                  frame_cnt;

    logic                         in_ready;
    logic                         out_valid;
    logic                         out_last;
    logic                         out_user;
    logic [P_AXIS_DATA_WIDTH-1:0] out_data;
    logic                         skid_valid;
    logic                         skid_last;
    logic                         skid_user;
    logic [P_AXIS_DATA_WIDTH-1:0] skid_data;

    logic in_fire;
    logic run_fire;
    logic line_end;
    logic frame_end;
    logic tag_last;
    logic tag_user;
    logic start_run;
    logic out_ready;
    logic skid_valid_nxt;

    assign in_fire   = s_axis.tvalid && in_ready;
    assign run_fire  = in_fire && (state == RUN);
    assign line_end  = (beat_cnt == line_beats_m1);
    assign frame_end = line_end && (line_cnt == frame_lines_m1);
    assign tag_user  = (beat_cnt == '0) && (line_cnt == '0);
    assign start_run = (state == IDLE) && i_enable;
    assign out_ready = !out_valid || m_axis.tready;

`ifdef AXIS_FRAME_TAGGER_EOL_EN
    assign tag_last = line_end;
`else
    assign tag_last = frame_end;
`endif

    always_ff @(posedge i_axi_clk or negedge i_axi_rstn) begin
        if (!i_axi_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A capture stop only takes effect once the frame in progress has fully entered.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_enable) state_nxt = RUN;
            RUN:     if (run_fire && frame_end && !i_enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Geometry is re-latched only at frame boundaries so mid-frame edits wait for the next frame.
    always_ff @(posedge i_axi_clk or negedge i_axi_rstn) begin
        if (!i_axi_rstn) begin
            beat_cnt       <= '0;
            line_cnt       <= '0;
            line_beats_m1  <= '0;
            frame_lines_m1 <= '0;
            frame_cnt      <= '0;
        end else if (start_run) begin
            beat_cnt       <= '0;
            line_cnt       <= '0;
            line_beats_m1  <= i_line_beats_m1;
            frame_lines_m1 <= i_frame_lines_m1;
        end else if (run_fire) begin
            if (line_end) begin
                beat_cnt <= '0;
                if (frame_end) begin
                    line_cnt       <= '0;
                    line_beats_m1  <= i_line_beats_m1;
                    frame_lines_m1 <= i_frame_lines_m1;
                    frame_cnt      <= frame_cnt + 32'd1;
                end else begin
                    line_cnt <= line_cnt + 1'b1;
                end
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        skid_valid_nxt = skid_valid;
        if (out_ready) begin
            skid_valid_nxt = 1'b0;
        end else if (run_fire) begin
            skid_valid_nxt = 1'b1;
        end
    end

    // While RUN and ready, the skid entry is known empty, so a new beat never collides with a skid drain.
    always_ff @(posedge i_axi_clk or negedge i_axi_rstn) begin
        if (!i_axi_rstn) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_user   <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
            skid_user  <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b0;
        end else begin
            if (out_ready) begin
                if (skid_valid) begin
                    out_data <= skid_data;
                    out_last <= skid_last;
                    out_user <= skid_user;
                end else if (run_fire) begin
                    out_data <= s_axis.tdata;
                    out_last <= tag_last;
                    out_user <= tag_user;
                end
                out_valid <= skid_valid || run_fire;
            end else if (run_fire) begin
                skid_data <= s_axis.tdata;
                skid_last <= tag_last;
                skid_user <= tag_user;
            end
            skid_valid <= skid_valid_nxt;
            in_ready   <= (state_nxt == IDLE) || !skid_valid_nxt;
        end
    end

    assign s_axis.tready = in_ready;
    assign m_axis.tvalid = out_valid;
    assign m_axis.tdata  = out_data;
    assign m_axis.tlast  = out_last;
    assign m_axis.tuser  = out_user;
    assign o_frame_cnt   = frame_cnt;
    assign o_busy        = (state == RUN);

endmodule
